button_debouncer: RTL and testbench

Debounce and edge-detect controller for the button-parser front end of the scan-chain bring-up logic. It consumes per-button signals that the two-flop synchronizer has already brought into the `clk` domain. A shared sample-tick counter schedules when every button channel is sampled, and a per-channel saturating counter decides when a press is stable. Outputs are a clean level per button and a one-cycle press pulse that the downstream scan-chain command logic consumes.

---
 rtl/button_debouncer.sv | 76 +++++++
 tb/tb_button_debouncer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// button_debouncer: per-channel saturating-count debouncer with a shared
// sample scheduler and a one-cycle press pulse on each debounced rising edge.
module button_debouncer #(
  parameter int unsigned WIDTH          = 1,
  parameter int unsigned SAMPLE_CNT_MAX = 25000,
  parameter int unsigned PULSE_CNT_MAX  = 150
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] glitchy_signal,
  output logic [WIDTH-1:0] debounced_signal,
  output logic [WIDTH-1:0] press_pulse
);

  localparam int unsigned TICK_W = $clog2(SAMPLE_CNT_MAX);
  localparam int unsigned CNT_W  = $clog2(PULSE_CNT_MAX + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CNT_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(PULSE_CNT_MAX);

  logic [TICK_W-1:0] tick_cnt;
  logic              sample_tick;
  logic [CNT_W-1:0]  cnt [WIDTH];
  logic [WIDTH-1:0]  prev;

  // One sample strobe per period, on the last count before wrap.
  assign sample_tick = (tick_cnt == TICK_LAST);

  // Shared sample-tick counter; reset restarts the phase at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (sample_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Per-channel consecutive-high counter, saturating; any low sample clears it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (rst) begin
        cnt[i] <= '0;
      end else if (sample_tick) begin
        if (!glitchy_signal[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] != CNT_SAT) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Clean level decoded straight from registered counter state.
  always_comb begin
    debounced_signal = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      debounced_signal[i] = (cnt[i] == CNT_SAT);
    end
  end

  // Previous-cycle level for rising-edge detection; reset clears it so a
  // reset-induced drop never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= '0;
    end else begin
      prev <= debounced_signal;
    end
  end

  // Press pulse on the first cycle the debounced level is high.
  assign press_pulse = debounced_signal & ~prev;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: directed test-plan scenarios with
// literal expectations, then randomized stimulus against a sample-history model.
module tb_button_debouncer;

  localparam int W = 2;
  localparam int S = 4;
  localparam int P = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] glitchy_signal = '0;
  logic [W-1:0] debounced_signal;
  logic [W-1:0] press_pulse;

  int checks = 0;
  int errors = 0;

  button_debouncer #(
    .WIDTH(W), .SAMPLE_CNT_MAX(S), .PULSE_CNT_MAX(P)
  ) u_dut (
    .clk(clk), .rst(rst), .glitchy_signal(glitchy_signal),
    .debounced_signal(debounced_signal), .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Keeps the tick samples since reset; a channel is debounced when the most
  // recent P samples were all high.
  logic [W-1:0] samples[$];
  int           cyc = 0;
  bit           valid = 0;
  logic [W-1:0] exp_deb = '0;
  logic [W-1:0] exp_pulse = '0;

  always @(posedge clk) begin
    logic [W-1:0] nd;
    if (rst) begin
      valid     = 1;
      cyc       = 0;
      samples.delete();
      exp_deb   = '0;
      exp_pulse = '0;
    end else if (valid) begin
      if (cyc % S == S - 1) begin
        samples.push_back(glitchy_signal);
        if (samples.size() > P) void'(samples.pop_front());
      end
      cyc++;
      nd = '0;
      for (int ch = 0; ch < W; ch++) begin
        nd[ch] = (samples.size() == P);
        foreach (samples[k]) if (!samples[k][ch]) nd[ch] = 1'b0;
      end
      exp_pulse = nd & ~exp_deb;
      exp_deb   = nd;
    end
  end

  // Compare DUT outputs to the model every cycle once reset has been seen.
  always @(negedge clk) begin
    if (valid) begin
      chk("model_debounced", 32'(debounced_signal), 32'(exp_deb));
      chk("model_pulse",     32'(press_pulse),      32'(exp_pulse));
    end
  end

  // ---------------- directed scenarios ----------------
  function automatic logic [W-1:0] stim(input int id, input int c);
    case (id)
      1: return 2'b01;
      2: return (c == 11) ? 2'b00 : 2'b01;
      3: return (c == 5 || c == 6) ? 2'b00 : 2'b01;
      4: return (c >= 4 && c <= 6) ? 2'b01 : 2'b00;
      5: return (c >= 20 && c < 24) ? 2'b00 : 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [W-1:0] lit_deb(input int id, input int c);
    if (c < 0) return 2'b00;
    case (id)
      1, 3: return (c >= 12) ? 2'b01 : 2'b00;
      2:    return (c >= 24) ? 2'b01 : 2'b00;
      4:    return 2'b00;
      5:    return ((c >= 12 && c < 24) || c >= 36) ? 2'b01 : 2'b00;
      default: return (c >= 12) ? 2'b11 : 2'b00;
    endcase
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    glitchy_signal = 2'b11;
    repeat (n) begin
      @(posedge clk); #1;
      chk("reset_debounced", 32'(debounced_signal), 0);
      chk("reset_pulse",     32'(press_pulse),      0);
    end
    rst = 1'b0;
  endtask

  // Runs cycles 0..ncyc-1 of a scenario; called right after reset deasserts.
  task automatic run(input int id, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      glitchy_signal = stim(id, c);
      #2;
      chk($sformatf("s%0d_deb_c%0d", id, c), 32'(debounced_signal), 32'(lit_deb(id, c)));
      chk($sformatf("s%0d_pulse_c%0d", id, c), 32'(press_pulse),
          32'(lit_deb(id, c) & ~lit_deb(id, c - 1)));
      if (c == 0) chk("tick_cnt_cycle0", 32'(u_dut.tick_cnt), 0);
      if (id == 1 && c == 4)  chk("s1_cnt_after_t3",  32'(u_dut.cnt[0]), 1);
      if (id == 1 && c == 8)  chk("s1_cnt_after_t7",  32'(u_dut.cnt[0]), 2);
      if (id == 1 && c == 12) chk("s1_cnt_after_t11", 32'(u_dut.cnt[0]), 3);
      if (id == 1 && c == 14) chk("s1_cnt_saturated", 32'(u_dut.cnt[0]), 3);
      if (id == 2 && c == 12) chk("s2_cnt_cleared",   32'(u_dut.cnt[0]), 0);
      if (id == 4 && c == 8)  chk("s4_cnt_zero",      32'(u_dut.cnt[0]), 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [W-1:0] lvl;
    @(posedge clk); #1;

    do_reset(3); run(1, 16);
    do_reset(3); run(2, 30);
    do_reset(3); run(3, 16);
    do_reset(3); run(4, 12);
    do_reset(3); run(5, 40);
    do_reset(3); run(6, 16);
    // Reset abort in cycle 9: no pulse before it, fresh phase after it.
    do_reset(3); run(6, 9);
    do_reset(1); run(6, 16);

    // Randomized phase with occasional resets and short glitches.
    do_reset(2);
    lvl = '0;
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int ch = 0; ch < W; ch++) begin
        if ($urandom_range(0, 15) == 0) lvl[ch] = ~lvl[ch];
      end
      glitchy_signal = lvl ^ W'($urandom_range(0, 40) == 0 ? $urandom_range(1, 3) : 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
